// File: rtl/bpu_gshare_pkg.sv
// rtl/bpu_gshare_pkg.sv - shared constants and helpers for the gshare predictor
//
// Purpose: 2-bit counter encodings, FSM state encodings and the saturating
// counter update used by bpu_gshare.
// Ports: none (package).
package bpu_gshare_pkg;

  // 2-bit direction counter states
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Predictor FSM states
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Move a counter one step toward ST (taken) or SNT (not taken), holding at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bpu_btb.sv
// rtl/bpu_btb.sv - tagged branch target buffer for the gshare predictor
//
// Purpose: direct-mapped array of valid/tag/target entries with one
// combinational read port and one synchronous write port.
// Ports:
//   clk          clock
//   clr_i        synchronous clear of all valid bits
//   rd_idx_i     read index            rd_tag_i    read tag
//   rd_hit_o     valid & tag match     rd_target_o stored target at rd_idx_i
//   wr_en_i      write strobe          wr_idx_i    write index
//   wr_tag_i     tag to store          wr_target_i target to store
module bpu_btb
  import bpu_gshare_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  localparam int BI    = $clog2(DEPTH),
  localparam int TAG_W = XLEN - BI - 2
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [BI-1:0]    rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_hit_o,
  output logic [XLEN-1:0]  rd_target_o,
  input  logic             wr_en_i,
  input  logic [BI-1:0]    wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  wr_target_i
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  // Reads see the contents before any same-cycle write.
  assign rd_hit_o    = valid_q[rd_idx_i] & (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = target_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/bpu_gshare.sv
// rtl/bpu_gshare.sv - gshare direction predictor with tagged BTB
//
// Purpose: one lookup per cycle with a registered prediction, speculative
// global history, training and history repair from the resolve stage.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   o_ready            high once the PHT init sweep has finished
//   i_req_valid/pc     lookup request
//   o_pred_valid       prediction valid, one cycle after an accepted request
//   o_pred_taken       predicted direction
//   o_pred_target      predicted next PC
//   o_pred_ghr         history used to index this prediction
//   i_upd_valid/pc     resolved branch
//   i_upd_target       resolved taken target
//   i_upd_taken        actual direction
//   i_upd_mispredict   repair history from i_upd_ghr
//   i_upd_ghr          history that was returned with the prediction
module bpu_gshare
  import bpu_gshare_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PHT_DEPTH = 256,
  parameter int BTB_DEPTH = 64,
  localparam int GHR_W     = $clog2(PHT_DEPTH),
  localparam int BI        = $clog2(BTB_DEPTH),
  localparam int TAG_W     = XLEN - BI - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_ready,
  input  logic             i_req_valid,
  input  logic [XLEN-1:0]  i_req_pc,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_target,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_upd_valid,
  input  logic [XLEN-1:0]  i_upd_pc,
  input  logic [XLEN-1:0]  i_upd_target,
  input  logic             i_upd_taken,
  input  logic             i_upd_mispredict,
  input  logic [GHR_W-1:0] i_upd_ghr
);

  logic [0:0]       state_q, state_d;
  logic [GHR_W-1:0] sweep_q, sweep_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [1:0]       pht_q [PHT_DEPTH];

  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;
  logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;

  logic             run;
  logic             req_fire;
  logic             upd_fire;
  logic [GHR_W-1:0] req_pht_idx;
  logic [GHR_W-1:0] upd_pht_idx;
  logic             btb_hit;
  logic [XLEN-1:0]  btb_target;
  logic             lookup_taken;
  logic             unused_upd_pc_lsb;

  assign run         = (state_q == S_RUN);
  assign req_fire    = i_req_valid & run;
  assign upd_fire    = i_upd_valid & run;
  assign req_pht_idx = i_req_pc[GHR_W+1:2] ^ ghr_q;
  assign upd_pht_idx = i_upd_pc[GHR_W+1:2] ^ i_upd_ghr;

  // Byte offset within the instruction word never affects training.
  assign unused_upd_pc_lsb = ^i_upd_pc[1:0];

  bpu_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .clr_i       (~rst_n),
    .rd_idx_i    (i_req_pc[BI+1:2]),
    .rd_tag_i    (i_req_pc[XLEN-1:BI+2]),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .wr_en_i     (upd_fire & i_upd_taken),
    .wr_idx_i    (i_upd_pc[BI+1:2]),
    .wr_tag_i    (i_upd_pc[XLEN-1:BI+2]),
    .wr_target_i (i_upd_target)
  );

  // A BTB miss always predicts not-taken, whatever the counter says.
  assign lookup_taken = btb_hit & pht_q[req_pht_idx][1];

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == S_INIT) begin
      sweep_d = sweep_q + GHR_W'(1);
      if (sweep_q == GHR_W'(PHT_DEPTH - 1)) state_d = S_RUN;
    end
  end

  // Repair from the resolve stage overrides the speculative shift; the
  // same-cycle request was already indexed with the old history.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_fire && i_upd_mispredict) begin
      ghr_d = {i_upd_ghr[GHR_W-2:0], i_upd_taken};
    end else if (req_fire && btb_hit) begin
      ghr_d = {ghr_q[GHR_W-2:0], lookup_taken};
    end
  end

  always_comb begin
    pred_valid_d  = req_fire;
    pred_taken_d  = req_fire & lookup_taken;
    pred_target_d = '0;
    pred_ghr_d    = '0;
    if (req_fire) begin
      pred_target_d = lookup_taken ? btb_target : (i_req_pc + XLEN'(4));
      pred_ghr_d    = ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      sweep_q       <= '0;
      ghr_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      ghr_q         <= ghr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_ghr_q    <= pred_ghr_d;
    end
  end

  // The PHT has no reset of its own; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        pht_q[sweep_q] <= WNT;
      end else if (i_upd_valid) begin
        pht_q[upd_pht_idx] <= sat_update(pht_q[upd_pht_idx], i_upd_taken);
      end
    end
  end

  assign o_ready       = run;
  assign o_pred_valid  = pred_valid_q;
  assign o_pred_taken  = pred_taken_q;
  assign o_pred_target = pred_target_q;
  assign o_pred_ghr    = pred_ghr_q;

endmodule

// File: tb/tb_bpu_gshare.sv
// tb/tb_bpu_gshare.sv - scoreboard bench for bpu_gshare against a behavioural model
module tb_bpu_gshare;

  localparam int XLEN      = 32;
  localparam int PHT_DEPTH = 256;
  localparam int BTB_DEPTH = 64;
  localparam int GHR_W     = 8;
  localparam int BI_TB     = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             o_ready;
  logic             i_req_valid;
  logic [XLEN-1:0]  i_req_pc;
  logic             o_pred_valid;
  logic             o_pred_taken;
  logic [XLEN-1:0]  o_pred_target;
  logic [GHR_W-1:0] o_pred_ghr;
  logic             i_upd_valid;
  logic [XLEN-1:0]  i_upd_pc;
  logic [XLEN-1:0]  i_upd_target;
  logic             i_upd_taken;
  logic             i_upd_mispredict;
  logic [GHR_W-1:0] i_upd_ghr;

  bpu_gshare #(
    .XLEN      (XLEN),
    .PHT_DEPTH (PHT_DEPTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_ready          (o_ready),
    .i_req_valid      (i_req_valid),
    .i_req_pc         (i_req_pc),
    .o_pred_valid     (o_pred_valid),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .o_pred_ghr       (o_pred_ghr),
    .i_upd_valid      (i_upd_valid),
    .i_upd_pc         (i_upd_pc),
    .i_upd_target     (i_upd_target),
    .i_upd_taken      (i_upd_taken),
    .i_upd_mispredict (i_upd_mispredict),
    .i_upd_ghr        (i_upd_ghr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: counters as integers 0..3, history as an integer mod PHT_DEPTH.
  int              pht_m [PHT_DEPTH];
  bit              bv_m  [BTB_DEPTH];
  int unsigned     btag_m[BTB_DEPTH];
  logic [XLEN-1:0] btgt_m[BTB_DEPTH];
  int              ghr_m;
  int              init_cnt;

  typedef struct {
    logic             taken;
    logic [XLEN-1:0]  target;
    logic [GHR_W-1:0] ghr;
    int               stamp;
  } exp_t;
  exp_t expq[$];

  function automatic int pht_idx(input logic [XLEN-1:0] pc, input int g);
    return int'((pc >> 2) % PHT_DEPTH) ^ g;
  endfunction

  function automatic int btb_idx(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % BTB_DEPTH);
  endfunction

  function automatic int unsigned btb_tag(input logic [XLEN-1:0] pc);
    return int'(pc >> (BI_TB + 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PHT_DEPTH; i++) pht_m[i] = 1;
    for (int i = 0; i < BTB_DEPTH; i++) bv_m[i] = 1'b0;
    ghr_m    = 0;
    init_cnt = 0;
  endtask

  // One clock of stimulus: drive at the falling edge, predict what the rising edge does.
  task automatic cycle(input bit rq, input logic [XLEN-1:0] rpc,
                       input bit uv, input logic [XLEN-1:0] upc, input logic [XLEN-1:0] utgt,
                       input bit ut, input bit um, input logic [GHR_W-1:0] ug);
    exp_t e;
    bit   run;
    bit   hit;
    bit   tk;
    int   bi;
    int   p;
    int   new_ghr;
    @(negedge clk);
    rst_n            = 1'b1;
    i_req_valid      = rq;
    i_req_pc         = rpc;
    i_upd_valid      = uv;
    i_upd_pc         = upc;
    i_upd_target     = utgt;
    i_upd_taken      = ut;
    i_upd_mispredict = um;
    i_upd_ghr        = ug;
    run = (init_cnt >= PHT_DEPTH);
    init_cnt++;
    if (!run) return;
    new_ghr = ghr_m;
    if (rq) begin
      bi  = btb_idx(rpc);
      hit = bv_m[bi] && (btag_m[bi] == btb_tag(rpc));
      tk  = hit && (pht_m[pht_idx(rpc, ghr_m)] >= 2);
      e.taken  = tk;
      e.target = tk ? btgt_m[bi] : rpc + 32'd4;
      e.ghr    = GHR_W'(ghr_m);
      e.stamp  = cyc;
      expq.push_back(e);
      if (hit) new_ghr = (ghr_m * 2 + int'(tk)) % PHT_DEPTH;
    end
    if (uv) begin
      p = pht_idx(upc, int'(ug));
      if (ut) pht_m[p] = (pht_m[p] == 3) ? 3 : pht_m[p] + 1;
      else    pht_m[p] = (pht_m[p] == 0) ? 0 : pht_m[p] - 1;
      if (ut) begin
        bi = btb_idx(upc);
        bv_m[bi]   = 1'b1;
        btag_m[bi] = btb_tag(upc);
        btgt_m[bi] = utgt;
      end
      if (um) new_ghr = (int'(ug) * 2 + int'(ut)) % PHT_DEPTH;
    end
    ghr_m = new_ghr;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input bit with_req);
    @(negedge clk);
    rst_n       = 1'b0;
    i_req_valid = with_req;
    i_req_pc    = 32'h100;
    i_upd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    i_req_valid = 1'b0;
    check("rst_ready", 64'(o_ready), 64'(0));
    check("rst_pred_valid", 64'(o_pred_valid), 64'(0));
    check("rst_pred_fields", {23'd0, o_pred_taken, o_pred_target, o_pred_ghr}, 64'(0));
    @(negedge clk);
  endtask

  // Requests and taken updates are driven throughout INIT and must be ignored.
  task automatic init_phase();
    int n;
    n = 0;
    while (n < 400) begin
      cycle(1'b1, 32'h7F0, 1'b1, 32'h7F0, 32'h900, 1'b1, 1'b0, 8'h00);
      if (o_ready === 1'b1) break;
      n++;
    end
    check("ready_latency", 64'(n), 64'(PHT_DEPTH));
  endtask

  // Monitor: pops an expectation whose request has reached a clock edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0 && expq[0].stamp < cyc) begin
        e = expq.pop_front();
        check("pred_valid", 64'(o_pred_valid), 64'(1));
        if (o_pred_valid === 1'b1) begin
          check("pred_taken", 64'(o_pred_taken), 64'(e.taken));
          check("pred_target", 64'(o_pred_target), 64'(e.target));
          check("pred_ghr", 64'(o_pred_ghr), 64'(e.ghr));
        end
      end else begin
        check("idle_valid", 64'(o_pred_valid), 64'(0));
        check("idle_fields", {23'd0, o_pred_taken, o_pred_target, o_pred_ghr}, 64'(0));
      end
    end
  end

  initial begin : stim
    logic [XLEN-1:0] rp;
    logic [XLEN-1:0] up;
    rst_n            = 1'b0;
    i_req_valid      = 1'b0;
    i_req_pc         = '0;
    i_upd_valid      = 1'b0;
    i_upd_pc         = '0;
    i_upd_target     = '0;
    i_upd_taken      = 1'b0;
    i_upd_mispredict = 1'b0;
    i_upd_ghr        = '0;
    model_reset();
    do_reset(1'b0);
    init_phase();
    idle();

    // Cold lookups, including pc+4 wrapping past the top of the address space.
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    // Train taken twice, then look up: hit, taken, history shifts.
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    // Repair history back to 0, then drive the counter to SNT and beyond.
    cycle(1'b0, '0, 1'b1, 32'h900, 32'h0, 1'b0, 1'b1, 8'h80);
    repeat (5) cycle(1'b0, '0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    // Mispredict repair concurrent with a request.
    cycle(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 8'hA5);
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    // Same-cycle allocate and lookup, then lookup again.
    cycle(1'b1, 32'h3000, 1'b1, 32'h3000, 32'h4000, 1'b1, 1'b0, GHR_W'(ghr_m));
    cycle(1'b1, 32'h3000, 1'b0, '0, '0, 1'b0, 1'b0, '0);

    // Random traffic over a small PC pool so BTB hits, conflicts and tag misses all occur.
    for (int i = 0; i < 1500; i++) begin
      rp = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2)
           + 32'($urandom_range(0, 3));
      up = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2)
           + 32'($urandom_range(0, 3));
      cycle(($urandom_range(0, 9) < 7), rp,
            ($urandom_range(0, 1) == 1), up, 32'($urandom),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
            GHR_W'($urandom_range(0, PHT_DEPTH - 1)));
    end

    // Reset mid-RUN with a request on the same edge, then re-initialise.
    do_reset(1'b1);
    init_phase();
    cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) idle();
    check("queue_drained", 64'(expq.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bpu_gshare.md
# bpu_gshare

Parametrised gshare branch predictor with a tagged branch target buffer (BTB), the next generation of the fetch-stage predictor. It accepts one lookup per cycle from IF and returns a registered taken/not-taken prediction and target. It also returns the global-history snapshot used for the lookup. A separate resolution port, driven from the branch-resolve stage, trains the counters and BTB and repairs the speculative history on a mispredict.

## Interface
- XLEN, 32, PC/target width
- PHT_DEPTH, 256, pattern-history entries (power of 2, ≥4); GHR_W = log2(PHT_DEPTH)
- BTB_DEPTH, 64, BTB entries (power of 2, ≥2); BI = log2(BTB_DEPTH)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- o_ready  out  1  high once init sweep is complete
- i_req_valid  in  1  lookup request
- i_req_pc  in  XLEN  PC being fetched
- o_pred_valid  out  1  prediction valid (one cycle after the accepted request)
- o_pred_taken  out  1  predicted direction
- o_pred_target  out  XLEN  predicted next PC
- o_pred_ghr  out  GHR_W  history used to index this prediction
- i_upd_valid  in  1  resolved branch
- i_upd_pc  in  XLEN  resolved branch PC
- i_upd_target  in  XLEN  resolved taken target
- i_upd_taken  in  1  actual direction
- i_upd_mispredict  in  1  prediction was wrong; repair history
- i_upd_ghr  in  GHR_W  o_pred_ghr returned with the branch

## Operation
- FSM states INIT and RUN. Reset enters INIT with the sweep index at 0.
- INIT: one PHT entry is written to WNT (01) per cycle. All BTB valid bits are cleared in the reset cycle. After PHT_DEPTH cycles the FSM moves to RUN and o_ready rises.
- During INIT, requests and updates are ignored and o_pred_valid stays 0.
- Indexing:
  - PHT index = pc[GHR_W+1:2] ^ ghr.
  - BTB index = pc[BI+1:2].
  - BTB tag = pc[XLEN-1:BI+2].
  - pc[1:0] is ignored.
- Lookup in RUN:
  - hit = valid[idx] & (tag match).
  - taken = hit & pht[idx][1].
  - target = BTB target if taken, else pc+4 (mod 2^XLEN).
  - A miss predicts not-taken.
- Speculative history: on an accepted request that hits, ghr ← {ghr[GHR_W-2:0], taken}. On a miss, ghr is unchanged.
- Update in RUN (i_upd_valid):
  - PHT entry at i_upd_pc[GHR_W+1:2] ^ i_upd_ghr saturates toward ST if taken, toward SNT if not taken.
  - If taken, the BTB entry is written with tag, i_upd_target and valid=1, allocating or overwriting. If not taken, the BTB is unchanged.
- Repair: i_upd_valid & i_upd_mispredict sets ghr ← {i_upd_ghr[GHR_W-2:0], i_upd_taken}. This has priority over a same-cycle speculative shift.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Saturation at 00 and 11 holds the value.

## Timing
- Reset values: o_ready=0, o_pred_valid=0, o_pred_taken=0, o_pred_target=0, o_pred_ghr=0, ghr=0.
- Lookup latency is 1 cycle. Outputs are registered.
- o_pred_valid = registered (i_req_valid & RUN). When it is low, the other prediction outputs are 0.
- Update applies at the next clk edge. There is no backpressure on either port.
- Same-cycle update and lookup to the same entry: the lookup returns the pre-update PHT and BTB contents.
- Same-cycle mispredict and request: the request is indexed with the old ghr. The resulting ghr is the repaired value.
- rst_n asserted mid-INIT or mid-RUN restarts INIT from index 0 and drops any in-flight prediction.

## Structure
- Shared header: counter state constants SNT/WNT/WT/ST and the FSM state encodings.
- Saturating counter logic is a function in the shared header.
- Natural sub-module is bpu_btb, holding the valid/tag/target arrays. It has one combinational read port and one synchronous write port.
- The PHT, GHR and FSM stay in bpu_gshare.

## Test plan
- Reset, then hold → o_ready rises exactly PHT_DEPTH (256) cycles after rst_n goes high. No o_pred_valid before that.
- Lookup 0x100 (cold) → o_pred_valid=1, taken=0, target=0x104, ghr unchanged at 0.
- Update pc=0x100, target=0x200, taken=1, ghr=0 twice, then lookup 0x100 with ghr=0 → taken=1, target=0x200, ghr becomes 0x01.
- Four not-taken updates on one index → counter saturates at SNT. A fifth update leaves it at 00.
- Mispredict update with i_upd_ghr=0xA5 and taken=1, concurrent with a request → request indexes with the old ghr; ghr=0x4B next cycle.
- Same-cycle update (BTB allocate) and lookup of the same PC → lookup misses. A lookup in the following cycle hits.
